fsm: RTL and testbench
======================

FSM -- requirements
Module: fsm

Interface
REQ-001 Port clk, input, 1: sole clock; all state updates on its rising edge.
REQ-002 Port rst_n, input, 1: asynchronous active-low reset.
REQ-003 Port m_sense, input, 7: soil-moisture reading, unsigned; higher means wetter.
REQ-004 Port m_thresh, input, 7: dryness threshold, unsigned; higher threshold means a less severe drought.
REQ-005 Port water_time_in, input, 7: base watering duration in clk cycles, unsigned.
REQ-006 Port water_toggle, output, 1: valve enable; 1 means watering.
REQ-007 Port state, output, 2: current FSM state encoding, driven directly from the state register.

Function
REQ-008 The block SHALL use four states: IDLE=2'b00, DISABLED=2'b01, WATER=2'b10, DEEP_WATER=2'b11.
REQ-009 water_toggle SHALL be 1 exactly when state is WATER or DEEP_WATER (Moore decode, same cycle as state).
REQ-010 IDLE, lockout==0, water_time_in==0: next state DISABLED.
REQ-011 IDLE, lockout==0, m_sense < (m_thresh>>1): next state DEEP_WATER; duration counter loaded with 2*water_time_in (8-bit).
REQ-012 Otherwise IDLE, lockout==0, m_sense < m_thresh: next state WATER; duration counter loaded with water_time_in.
REQ-013 m_sense == m_thresh SHALL NOT trigger watering; IDLE is held.
REQ-014 WATER/DEEP_WATER SHALL last exactly the loaded count in cycles, then return to IDLE; inputs are ignored while watering.
REQ-015 On exit from watering, an 11-bit soak-lockout counter SHALL load 16*water_time_in, latched at watering entry.
REQ-016 IDLE with lockout != 0 SHALL decrement lockout each cycle and ignore m_sense; state stays 2'b00.
REQ-017 DISABLED SHALL return to IDLE on the first cycle water_time_in != 0; water_toggle stays 0.
REQ-018 All arithmetic is unsigned and zero-extended; no counter may wrap.

Reset
REQ-019 rst_n low SHALL immediately force state=IDLE, water_toggle=0, duration=0, lockout=0, regardless of clk.
REQ-020 Reset asserted mid-watering SHALL stop watering at once; after release the block re-evaluates from IDLE with no lockout.

Structure
REQ-021 State encodings, the lockout multiplier (16) and the deep-drought divisor shift (1) SHALL reside in a shared package, fsm_pkg.
REQ-022 One sub-module, fsm_counter, SHALL be used: a loadable down-counter with zero flag, instantiated for duration and for lockout.

Verification
REQ-023 Reset, m_sense=127, m_thresh=100, water_time_in=3 -> state 00, water_toggle 0 indefinitely.
REQ-024 From the REQ-023 setup, set m_sense=90 -> state 10 and water_toggle 1 for exactly 3 cycles, then 00/0; state still 00 six cycles after entry.
REQ-025 Continuing REQ-024 with m_sense held at 90 -> state 00 for 48 lockout cycles, then re-enters 10.
REQ-026 m_sense=40, m_thresh=100, water_time_in=3 -> state 11 for 6 cycles, water_toggle 1, then 00.
REQ-027 water_time_in=0 -> state 01, water_toggle 0; set water_time_in=2 -> IDLE next cycle; m_sense=m_thresh=100 -> no watering.
REQ-028 Assert rst_n low during the 2nd WATER cycle -> state 00 and water_toggle 0 immediately, without waiting for a clk edge.

Source files
------------

// File: rtl/fsm_pkg.sv
// Shared encodings and constants for the irrigation controller FSM.
// Also holds the helpers the top level uses to decode and size its counters.
package fsm_pkg;

    typedef enum logic [1:0] {
        IDLE       = 2'b00,
        DISABLED   = 2'b01,
        WATER      = 2'b10,
        DEEP_WATER = 2'b11
    } state_t;

    localparam int unsigned  DUR_W        = 8;
    localparam int unsigned  LOCK_W       = 11;
    localparam logic [10:0]  LOCKOUT_MULT = 11'd16;
    localparam int unsigned  DEEP_SHIFT   = 1;

    function automatic logic is_watering(input state_t s);
        return (s == WATER) || (s == DEEP_WATER);
    endfunction

    function automatic logic [10:0] lockout_load(input logic [6:0] wt);
        return {4'b0000, wt} * LOCKOUT_MULT;
    endfunction

endpackage

// File: rtl/fsm_counter.sv
// Loadable saturating down-counter with zero flag.
// Load wins over decrement, and the count never wraps below zero.
module fsm_counter
    import fsm_pkg::*;
#(
    parameter int unsigned WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             load,
    input  logic [WIDTH-1:0] load_val,
    input  logic             dec,
    output logic [WIDTH-1:0] count,
    output logic             zero
);

    logic [WIDTH-1:0] count_r;

    // Count register: load has priority, decrement stops at zero.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count_r <= {WIDTH{1'b0}};
        end else if (load) begin
            count_r <= load_val;
        end else if (dec && (count_r != {WIDTH{1'b0}})) begin
            count_r <= count_r - WIDTH'(1);
        end else begin
            count_r <= count_r;
        end
    end

    assign count = count_r;
    assign zero  = (count_r == {WIDTH{1'b0}});

endmodule

// File: rtl/fsm.sv
// Soil-moisture irrigation controller: normal and deep watering, followed by a
// soak lockout that scales with the watering duration latched at entry.
module fsm
    import fsm_pkg::*;
(
    input  logic       clk,
    input  logic       rst_n,
    input  logic [6:0] m_sense,
    input  logic [6:0] m_thresh,
    input  logic [6:0] water_time_in,
    output logic       water_toggle,
    output logic [1:0] state
);

    state_t              state_r;
    state_t              next_state_s;
    logic                water_toggle_r;
    logic                water_next_s;
    logic [6:0]          wt_latched_r;
    logic                latch_s;

    logic                dur_load_s;
    logic [DUR_W-1:0]    dur_val_s;
    logic                dur_dec_s;
    logic [DUR_W-1:0]    dur_count_s;
    logic                dur_zero_s;

    logic                lock_load_s;
    logic                lock_dec_s;
    logic [LOCK_W-1:0]   lock_count_s;
    logic                lock_zero_s;

    fsm_counter #(.WIDTH(DUR_W)) u_duration (
        .clk      (clk),
        .rst_n    (rst_n),
        .load     (dur_load_s),
        .load_val (dur_val_s),
        .dec      (dur_dec_s),
        .count    (dur_count_s),
        .zero     (dur_zero_s)
    );

    fsm_counter #(.WIDTH(LOCK_W)) u_lockout (
        .clk      (clk),
        .rst_n    (rst_n),
        .load     (lock_load_s),
        .load_val (lockout_load(wt_latched_r)),
        .dec      (lock_dec_s),
        .count    (lock_count_s),
        .zero     (lock_zero_s)
    );

    // State, valve and latched-duration registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r        <= IDLE;
            water_toggle_r <= 1'b0;
            wt_latched_r   <= 7'd0;
        end else begin
            state_r        <= next_state_s;
            water_toggle_r <= water_next_s;
            wt_latched_r   <= latch_s ? water_time_in : wt_latched_r;
        end
    end

    // Next-state and counter control; inputs are only sampled in IDLE/DISABLED.
    always_comb begin
        next_state_s = state_r;
        dur_load_s   = 1'b0;
        dur_val_s    = {DUR_W{1'b0}};
        dur_dec_s    = 1'b0;
        lock_load_s  = 1'b0;
        lock_dec_s   = 1'b0;
        latch_s      = 1'b0;
        case (state_r)
            IDLE: begin
                if (!lock_zero_s) begin
                    lock_dec_s = 1'b1;
                end else if (water_time_in == 7'd0) begin
                    next_state_s = DISABLED;
                end else if (m_sense < (m_thresh >> DEEP_SHIFT)) begin
                    next_state_s = DEEP_WATER;
                    dur_load_s   = 1'b1;
                    dur_val_s    = {water_time_in, 1'b0};
                    latch_s      = 1'b1;
                end else if (m_sense < m_thresh) begin
                    next_state_s = WATER;
                    dur_load_s   = 1'b1;
                    dur_val_s    = {1'b0, water_time_in};
                    latch_s      = 1'b1;
                end else begin
                    next_state_s = IDLE;
                end
            end
            DISABLED: begin
                if (water_time_in != 7'd0) begin
                    next_state_s = IDLE;
                end else begin
                    next_state_s = DISABLED;
                end
            end
            WATER, DEEP_WATER: begin
                dur_dec_s = 1'b1;
                // The cycle holding a count of one is the last watering cycle.
                if (dur_count_s <= 8'd1) begin
                    next_state_s = IDLE;
                    lock_load_s  = 1'b1;
                end else begin
                    next_state_s = state_r;
                end
            end
            default: begin
                next_state_s = IDLE;
            end
        endcase
    end

    // Valve decode of the upcoming state so the registered valve tracks state.
    always_comb begin
        water_next_s = is_watering(next_state_s);
    end

    assign state        = state_r;
    assign water_toggle = water_toggle_r;

endmodule

// File: tb/tb_fsm.sv
// Directed self-checking bench for the irrigation controller FSM.
module tb_fsm;

    logic       clk;
    logic       rst_n;
    logic [6:0] m_sense;
    logic [6:0] m_thresh;
    logic [6:0] water_time_in;
    logic       water_toggle;
    logic [1:0] state;

    int checks   = 0;
    int failures = 0;

    fsm dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .m_sense       (m_sense),
        .m_thresh      (m_thresh),
        .water_time_in (water_time_in),
        .water_toggle  (water_toggle),
        .state         (state)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [7:0] got, input logic [7:0] exp);
        checks++;
        assert (got === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, got, exp);
        end
    endtask

    task automatic chk_st(input string tag, input logic [1:0] exp_state, input logic exp_tog);
        chk({tag, "_state"}, {6'd0, state}, {6'd0, exp_state});
        chk({tag, "_valve"}, {7'd0, water_toggle}, {7'd0, exp_tog});
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst_n         = 1'b0;
        m_sense       = 7'd127;
        m_thresh      = 7'd100;
        water_time_in = 7'd3;
        #2;
        chk_st("reset", 2'b00, 1'b0);
        step();
        rst_n = 1'b1;

        // Wet soil: no watering.
        for (int i = 0; i < 5; i++) begin
            step();
            chk_st("wet_idle", 2'b00, 1'b0);
        end

        // Normal watering for exactly 3 cycles.
        m_sense = 7'd90;
        for (int i = 0; i < 3; i++) begin
            step();
            chk_st("water", 2'b10, 1'b1);
        end

        // Lockout 48 cycles plus the evaluation cycle, all in IDLE.
        for (int i = 0; i < 49; i++) begin
            step();
            chk_st("lockout", 2'b00, 1'b0);
        end
        step();
        chk_st("rewater", 2'b10, 1'b1);

        // Reset during the second WATER cycle takes effect with no clock edge.
        step();
        chk_st("water2nd", 2'b10, 1'b1);
        #2;
        rst_n = 1'b0;
        #1;
        chk_st("async_rst", 2'b00, 1'b0);

        // Deep drought: 2*3 = 6 cycles.
        m_sense = 7'd40;
        step();
        rst_n = 1'b1;
        for (int i = 0; i < 6; i++) begin
            step();
            chk_st("deep", 2'b11, 1'b1);
        end
        step();
        chk_st("deep_exit", 2'b00, 1'b0);

        // Zero duration disables until a nonzero duration arrives.
        rst_n         = 1'b0;
        water_time_in = 7'd0;
        step();
        rst_n = 1'b1;
        step();
        chk_st("disabled", 2'b01, 1'b0);
        step();
        chk_st("disabled_hold", 2'b01, 1'b0);
        water_time_in = 7'd2;
        m_sense       = 7'd100;
        step();
        chk_st("enable", 2'b00, 1'b0);

        // Equal reading and threshold never waters.
        for (int i = 0; i < 3; i++) begin
            step();
            chk_st("equal", 2'b00, 1'b0);
        end

        // 50 is not below 100>>1, so normal watering for 2 cycles.
        m_sense = 7'd50;
        step();
        chk_st("half_water", 2'b10, 1'b1);
        step();
        chk_st("half_water2", 2'b10, 1'b1);
        step();
        chk_st("half_exit", 2'b00, 1'b0);

        // 49 is below the halved threshold: deep watering for 4 cycles.
        rst_n   = 1'b0;
        m_sense = 7'd49;
        step();
        rst_n = 1'b1;
        for (int i = 0; i < 4; i++) begin
            step();
            chk_st("deep49", 2'b11, 1'b1);
        end
        step();
        chk_st("deep49_exit", 2'b00, 1'b0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
